// File: rtl/board_supervisor_if.sv
// Signal bundle between the board supervisor and the rest of the avionics top level.
// The master drives the request/status inputs; the slave (the supervisor) drives the outputs.
interface board_supervisor_if #(
    parameter int TS_WIDTH = 24
);
    logic                tick;
    logic                start_req;
    logic                shutdown_req;
    logic                arm_req;
    logic                throttle_low;
    logic                radio_ok;
    logic                imu_ok;
    logic [1:0]          state;
    logic                subsys_rst;
    logic                motor_en;
    logic                failsafe;
    logic [TS_WIDTH-1:0] timestamp;

    modport master (
        output tick, start_req, shutdown_req, arm_req, throttle_low, radio_ok, imu_ok,
        input  state, subsys_rst, motor_en, failsafe, timestamp
    );

    modport slave (
        input  tick, start_req, shutdown_req, arm_req, throttle_low, radio_ok, imu_ok,
        output state, subsys_rst, motor_en, failsafe, timestamp
    );
endinterface

// File: rtl/board_supervisor.sv
// Board-level supervisor: IDLE/STARTUP/RUNNING/SHUTDOWN sequencing, motor arming
// interlock, radio-loss failsafe and the mission timestamp. All outputs are registered.
module board_supervisor #(
    parameter int TS_WIDTH       = 24,
    parameter int STARTUP_TICKS  = 100,
    parameter int SHUTDOWN_TICKS = 50,
    parameter int FAILSAFE_TICKS = 250,
    parameter int AUTO_START     = 1
) (
    input logic               clk,
    input logic               rst_n,
    board_supervisor_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_STARTUP  = 2'd1;
    localparam logic [1:0] S_RUNNING  = 2'd2;
    localparam logic [1:0] S_SHUTDOWN = 2'd3;

    localparam int PH_MAX = (STARTUP_TICKS > SHUTDOWN_TICKS) ? STARTUP_TICKS : SHUTDOWN_TICKS;
    localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);
    localparam int LS_W   = (FAILSAFE_TICKS < 1) ? 1 : $clog2(FAILSAFE_TICKS + 1);

    localparam logic [PH_W-1:0] ST_LIM = PH_W'(STARTUP_TICKS);
    localparam logic [PH_W-1:0] SD_LIM = PH_W'(SHUTDOWN_TICKS);
    localparam logic [LS_W-1:0] FS_LIM = LS_W'(FAILSAFE_TICKS);

    logic [1:0]          state_q, state_d;
    logic                subsys_rst_q;
    logic                motor_en_q, motor_en_d;
    logic                failsafe_q, failsafe_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [PH_W-1:0]     phase_q, phase_d, phase_lim;
    logic [LS_W-1:0]     loss_q, loss_d;
    logic                start_prev, shut_prev, arm_prev;
    logic                start_rise, shut_rise, arm_rise;
    logic                fs_trip;

    assign start_rise = bus.start_req    & ~start_prev;
    assign shut_rise  = bus.shutdown_req & ~shut_prev;
    assign arm_rise   = bus.arm_req      & ~arm_prev;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (AUTO_START != 0 || start_rise) state_d = S_STARTUP;
            end
            S_STARTUP: begin
                if (shut_rise)                              state_d = S_SHUTDOWN;
                else if (phase_q >= ST_LIM && bus.imu_ok)   state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (shut_rise) state_d = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                if (phase_q >= SD_LIM) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state change, so a tick on the transition edge is dropped.
    always_comb begin
        phase_lim = '0;
        if (state_q == S_STARTUP)       phase_lim = ST_LIM;
        else if (state_q == S_SHUTDOWN) phase_lim = SD_LIM;

        phase_d = phase_q;
        if (state_d != state_q)                   phase_d = '0;
        else if (bus.tick && phase_q < phase_lim) phase_d = phase_q + PH_W'(1);
    end

    always_comb begin
        loss_d = loss_q;
        if (bus.radio_ok)                     loss_d = '0;
        else if (bus.tick && loss_q < FS_LIM) loss_d = loss_q + LS_W'(1);
        fs_trip = !bus.radio_ok && (loss_d == FS_LIM);
    end

    // Arming interlock; a disarmed arm edge with failsafe latched only acknowledges the failsafe.
    always_comb begin
        motor_en_d = motor_en_q;
        failsafe_d = failsafe_q;
        if (state_q == S_RUNNING && !shut_rise && arm_rise) begin
            if (motor_en_q) begin
                motor_en_d = 1'b0;
            end else if (failsafe_q) begin
                if (bus.radio_ok) failsafe_d = 1'b0;
            end else if (bus.throttle_low && bus.radio_ok) begin
                motor_en_d = 1'b1;
            end
        end
        if (fs_trip) begin
            failsafe_d = 1'b1;
            motor_en_d = 1'b0;
        end
        if (state_d != S_RUNNING)                   motor_en_d = 1'b0;
        if (state_d == S_IDLE && state_q != S_IDLE) failsafe_d = 1'b0;
    end

    always_comb begin
        ts_d = ts_q;
        if (state_d != S_RUNNING)                 ts_d = '0;
        else if (state_q == S_RUNNING && bus.tick) ts_d = ts_q + TS_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            subsys_rst_q <= 1'b1;
            motor_en_q   <= 1'b0;
            failsafe_q   <= 1'b0;
            ts_q         <= '0;
            phase_q      <= '0;
            loss_q       <= '0;
            start_prev   <= 1'b0;
            shut_prev    <= 1'b0;
            arm_prev     <= 1'b0;
        end else begin
            state_q      <= state_d;
            subsys_rst_q <= (state_d == S_IDLE);
            motor_en_q   <= motor_en_d;
            failsafe_q   <= failsafe_d;
            ts_q         <= ts_d;
            phase_q      <= phase_d;
            loss_q       <= loss_d;
            start_prev   <= bus.start_req;
            shut_prev    <= bus.shutdown_req;
            arm_prev     <= bus.arm_req;
        end
    end

    assign bus.state      = state_q;
    assign bus.subsys_rst = subsys_rst_q;
    assign bus.motor_en   = motor_en_q;
    assign bus.failsafe   = failsafe_q;
    assign bus.timestamp  = ts_q;
endmodule

// File: tb/tb_board_supervisor.sv
// Bench for board_supervisor: vector table with a scoreboard queue for the auto-start build,
// plus hand-written sequences for async reset, manual start and timestamp wrap.
module tb_board_supervisor;
    logic clk;
    logic rst_n;
    logic rst2_n;

    board_supervisor_if #(.TS_WIDTH(24)) bus ();
    board_supervisor_if #(.TS_WIDTH(4))  b2 ();

    board_supervisor #(
        .TS_WIDTH(24), .STARTUP_TICKS(4), .SHUTDOWN_TICKS(3), .FAILSAFE_TICKS(3), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    board_supervisor #(
        .TS_WIDTH(4), .STARTUP_TICKS(1), .SHUTDOWN_TICKS(1), .FAILSAFE_TICKS(3), .AUTO_START(0)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          tk;
        bit          shut;
        bit          arm;
        bit          thr;
        bit          radio;
        bit          imu;
        int          n;
        logic [1:0]  st;
        bit          me;
        bit          fs;
        logic [23:0] ts;
        bit          sr;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        bit          me;
        bit          fs;
        logic [23:0] ts;
        bit          sr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(int tk, int sh, int ar, int th, int ra, int im, int n,
                                int st, int me, int fs, int ts, int sr);
        vec_t v;
        v.tk = (tk != 0); v.shut = (sh != 0); v.arm = (ar != 0);
        v.thr = (th != 0); v.radio = (ra != 0); v.imu = (im != 0);
        v.n = n; v.st = 2'(st); v.me = (me != 0); v.fs = (fs != 0);
        v.ts = 24'(ts); v.sr = (sr != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input exp_t e);
        chk({tag, ".state"},      32'(bus.state),      32'(e.st));
        chk({tag, ".motor_en"},   32'(bus.motor_en),   32'(e.me));
        chk({tag, ".failsafe"},   32'(bus.failsafe),   32'(e.fs));
        chk({tag, ".timestamp"},  32'(bus.timestamp),  32'(e.ts));
        chk({tag, ".subsys_rst"}, 32'(bus.subsys_rst), 32'(e.sr));
    endtask

    // Each tick pulse is a quiet cycle followed by a tick cycle, so checks land right after a tick edge.
    task automatic apply(input vec_t x);
        exp_t e;
        bus.shutdown_req = x.shut;
        bus.arm_req      = x.arm;
        bus.throttle_low = x.thr;
        bus.radio_ok     = x.radio;
        bus.imu_ok       = x.imu;
        e.st = x.st; e.me = x.me; e.fs = x.fs; e.ts = x.ts; e.sr = x.sr;
        sb.push_back(e);
        for (int i = 0; i < x.n; i++) begin
            if (x.tk) begin
                bus.tick = 1'b0;
                @(posedge clk); #1;
                bus.tick = 1'b1;
                @(posedge clk); #1;
                bus.tick = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            b2.tick = 1'b0;
            @(posedge clk); #1;
            b2.tick = 1'b1;
            @(posedge clk); #1;
            b2.tick = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bus.tick = 1'b0; bus.start_req = 1'b0; bus.shutdown_req = 1'b0; bus.arm_req = 1'b0;
        bus.throttle_low = 1'b0; bus.radio_ok = 1'b1; bus.imu_ok = 1'b1;
        b2.tick = 1'b0; b2.start_req = 1'b0; b2.shutdown_req = 1'b0; b2.arm_req = 1'b0;
        b2.throttle_low = 1'b0; b2.radio_ok = 1'b1; b2.imu_ok = 1'b1;

        //                tk sh ar th ra im   n   st me fs     ts sr
        vecs.push_back(mk(0, 1, 0, 0, 1, 1,   1,   3, 0, 0,     0, 0)); // shutdown from STARTUP
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   3,   3, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1,   0, 0, 0,     0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1,   1, 0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   3,   1, 0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   1,   1, 0, 0,     0, 0)); // 4th tick, still STARTUP
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1,   2, 0, 0,     0, 0)); // RUNNING next clk
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   3,   2, 0, 0,     3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1,   1,   2, 0, 0,     3, 0)); // throttle high: no arm
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 0, 0,     3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 1, 0,     3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 1, 0,     3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 0, 0,     3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 0, 0,     3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 1, 0,     3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 1, 0,     3, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1,   2,   2, 1, 0,     5, 0)); // 2 lost ticks
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 1, 0,     5, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1,   2,   2, 1, 0,     7, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1,   1,   2, 0, 1,     8, 0)); // 3rd lost tick trips
        vecs.push_back(mk(0, 0, 1, 1, 0, 1,   1,   2, 0, 1,     8, 0)); // radio still lost
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 0, 1,     8, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 0, 0,     8, 0)); // clears, does not arm
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 0, 0,     8, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 1, 0,     8, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 1, 0,     8, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1,   1,   3, 0, 0,     0, 0)); // shutdown beats arm
        vecs.push_back(mk(1, 0, 0, 1, 1, 1,   2,   3, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   3, 0, 0,     0, 0)); // arm ignored in SHUTDOWN
        vecs.push_back(mk(1, 0, 0, 1, 1, 1,   1,   3, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   0, 0, 0,     0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   1, 0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0,   8,   1, 0, 0,     0, 0)); // IMU not ready
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1,   2, 0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 291,   2, 0, 0, 'h123, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1,   1,   2, 1, 0, 'h123, 0));

        repeat (3) @(posedge clk);
        #1;
        e.st = 2'd0; e.me = 1'b0; e.fs = 1'b0; e.ts = '0; e.sr = 1'b1;
        chk_bus("reset", e);

        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release.state",      32'(bus.state),      32'd1);
        chk("release.subsys_rst", 32'(bus.subsys_rst), 32'd0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            if (sb.size() == 0) begin
                chk($sformatf("v%0d.scoreboard_empty", i), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_bus($sformatf("v%0d", i), e);
            end
        end

        // Asynchronous reset mid-cycle while armed in RUNNING.
        bus.arm_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        e.st = 2'd0; e.me = 1'b0; e.fs = 1'b0; e.ts = '0; e.sr = 1'b1;
        chk_bus("async_reset", e);

        // Manual-start build with a 4-bit timestamp.
        @(posedge clk); #1;
        chk("m.reset_state", 32'(b2.state), 32'd0);
        rst2_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("m.wait_state",      32'(b2.state),      32'd0);
        chk("m.wait_subsys_rst", 32'(b2.subsys_rst), 32'd1);
        b2.start_req = 1'b1;
        @(posedge clk); #1;
        chk("m.start_state",      32'(b2.state),      32'd1);
        chk("m.start_subsys_rst", 32'(b2.subsys_rst), 32'd0);
        b2.start_req = 1'b0;
        tick2(1);
        chk("m.tick1_state", 32'(b2.state), 32'd1);
        @(posedge clk); #1;
        chk("m.run_state", 32'(b2.state),     32'd2);
        chk("m.run_ts",    32'(b2.timestamp), 32'd0);
        tick2(15);
        chk("m.ts15", 32'(b2.timestamp), 32'd15);
        tick2(1);
        chk("m.ts_wrap",       32'(b2.timestamp), 32'd0);
        chk("m.ts_wrap_state", 32'(b2.state),     32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
